// File: rtl/xcalc_seq.sv
// Calculator sequencer: collects a, b, op from the switches, then runs the complement
// decoder and the ALU via start/done handshakes. Optional watchdog: define CALC_TIMEOUT_EN.
module xcalc_seq #(
    parameter int OP_MAX = 3,
    parameter int TMO_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_enter,
    input  logic        btn_clear,
    input  logic [7:0]  sw,
    output logic        cmp_start,
    output logic [11:0] cmp_data,
    input  logic        cmp_done,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [7:0]  alu_result,
    output logic [7:0]  disp_val,
    output logic        disp_sgn,
    output logic [1:0]  disp_msg,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {GET_A, GET_B, GET_OP, CONV, EXEC, SHOW, ERROR} state_t;

    localparam logic [1:0] MSG_VALUE = 2'b00;
    localparam logic [1:0] MSG_OP    = 2'b01;
    localparam logic [1:0] MSG_VAL   = 2'b10;
    localparam logic [1:0] MSG_ERR   = 2'b11;

    state_t     state;
    logic [3:0] a, b, op;
    logic       enter_q, clear_q;
    logic       enter_ev, clear_ev;
    logic       unused_sw;

    assign enter_ev  = btn_enter & ~enter_q;
    assign clear_ev  = btn_clear & ~clear_q;
    assign cmp_data  = {op, b, a};
    assign unused_sw = ^sw[7:4];

`ifdef CALC_TIMEOUT_EN
    // Reaching TMO_LAST on this edge means the counter becomes all-ones now.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo;
`else
    logic [TMO_W-1:0] unused_tmo;
    assign unused_tmo = '0;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the values from before this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= GET_A;
            a         <= '0;
            b         <= '0;
            op        <= '0;
            // Track the live button level so one held through reset gives no edge.
            enter_q   <= btn_enter;
            clear_q   <= btn_clear;
            cmp_start <= 1'b0;
            alu_start <= 1'b0;
            disp_val  <= '0;
            disp_sgn  <= 1'b0;
            disp_msg  <= MSG_VAL;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            tmo       <= '0;
`endif
        end else begin
            enter_q   <= btn_enter;
            clear_q   <= btn_clear;
            cmp_start <= 1'b0;
            alu_start <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            tmo       <= tmo + {{(TMO_W-1){1'b0}}, 1'b1};
`endif
            if (clear_ev) begin
                state    <= GET_A;
                a        <= '0;
                b        <= '0;
                op       <= '0;
                disp_msg <= MSG_VAL;
                busy     <= 1'b0;
                err      <= 1'b0;
            end else begin
                case (state)
                    GET_A: if (enter_ev) begin
                        a     <= sw[3:0];
                        state <= GET_B;
                    end
                    GET_B: if (enter_ev) begin
                        b        <= sw[3:0];
                        state    <= GET_OP;
                        disp_msg <= MSG_OP;
                    end
                    GET_OP: if (enter_ev) begin
                        op <= sw[3:0];
                        if (32'(sw[3:0]) > OP_MAX) begin
                            state    <= ERROR;
                            disp_msg <= MSG_ERR;
                            disp_val <= '0;
                            disp_sgn <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state     <= CONV;
                            cmp_start <= 1'b1;
                            disp_msg  <= MSG_VALUE;
                            busy      <= 1'b1;
`ifdef CALC_TIMEOUT_EN
                            tmo       <= '0;
`endif
                        end
                    end
                    // A done seen while our own start is still high is stale.
                    CONV: if (cmp_done && !cmp_start) begin
                        state     <= EXEC;
                        alu_start <= 1'b1;
`ifdef CALC_TIMEOUT_EN
                        tmo       <= '0;
                    end else if (tmo == TMO_LAST) begin
                        state    <= ERROR;
                        disp_msg <= MSG_ERR;
                        disp_val <= '0;
                        disp_sgn <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
`endif
                    end
                    EXEC: if (alu_done && !alu_start) begin
                        state    <= SHOW;
                        disp_sgn <= alu_result[7];
                        disp_val <= alu_result[7] ? (~alu_result + 8'd1) : alu_result;
                        busy     <= 1'b0;
`ifdef CALC_TIMEOUT_EN
                    end else if (tmo == TMO_LAST) begin
                        state    <= ERROR;
                        disp_msg <= MSG_ERR;
                        disp_val <= '0;
                        disp_sgn <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
`endif
                    end
                    SHOW: if (enter_ev) begin
                        state    <= GET_A;
                        a        <= '0;
                        b        <= '0;
                        op       <= '0;
                        disp_msg <= MSG_VAL;
                    end
                    ERROR: if (enter_ev) begin
                        state    <= GET_A;
                        disp_msg <= MSG_VAL;
                        err      <= 1'b0;
                    end
                    default: state <= GET_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xcalc_seq.sv
// Directed bench for xcalc_seq: table of full calculations plus hand-written
// sequences for reset, abort, clear/enter collision, op error and the CONV wait.
module tb_xcalc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_enter = 1'b0;
    logic        btn_clear = 1'b0;
    logic [7:0]  sw = '0;
    logic        cmp_done = 1'b0;
    logic        alu_done = 1'b0;
    logic [7:0]  alu_result = '0;
    logic        cmp_start, alu_start, disp_sgn, busy, err;
    logic [11:0] cmp_data;
    logic [7:0]  disp_val;
    logic [1:0]  disp_msg;

    xcalc_seq #(.OP_MAX(3), .TMO_W(4)) dut (
        .clk(clk), .rst(rst), .btn_enter(btn_enter), .btn_clear(btn_clear), .sw(sw),
        .cmp_start(cmp_start), .cmp_data(cmp_data), .cmp_done(cmp_done),
        .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
        .disp_val(disp_val), .disp_sgn(disp_sgn), .disp_msg(disp_msg),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_cmp = 0;
    int n_alu = 0;

    always @(negedge clk) begin
        if (cmp_start) n_cmp++;
        if (alu_start) n_alu++;
    end

    typedef struct {
        logic [3:0]  a, b, op;
        logic [7:0]  res;
        logic [11:0] data;
        logic [7:0]  val;
        logic        sgn;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        sw = {4'hA, v};
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        tick();
    endtask

    task automatic clear_press();
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        tick();
    endtask

    // Ends one cycle after the GET_OP enter edge, with the DUT in CONV.
    task automatic enter_op(input logic [3:0] v);
        sw = {4'h5, v};
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int c0, a0;
        c0 = n_cmp;
        a0 = n_alu;
        press(v.a);
        press(v.b);
        check($sformatf("v%0d msg_op", idx), 32'(disp_msg), 32'h1);
        enter_op(v.op);
        check($sformatf("v%0d cmp_start", idx), 32'(cmp_start), 32'h1);
        check($sformatf("v%0d busy_conv", idx), 32'(busy), 32'h1);
        check($sformatf("v%0d cmp_data", idx), 32'(cmp_data), 32'(v.data));
        cmp_done = 1'b1;
        tick();
        check($sformatf("v%0d early_done_ignored", idx), 32'(alu_start), 32'h0);
        tick();
        check($sformatf("v%0d alu_start", idx), 32'(alu_start), 32'h1);
        cmp_done   = 1'b0;
        alu_result = v.res;
        alu_done   = 1'b1;
        tick();
        check($sformatf("v%0d busy_exec", idx), 32'(busy), 32'h1);
        tick();
        alu_done = 1'b0;
        check($sformatf("v%0d busy_show", idx), 32'(busy), 32'h0);
        check($sformatf("v%0d msg_show", idx), 32'(disp_msg), 32'h0);
        check($sformatf("v%0d disp_val", idx), 32'(disp_val), 32'(v.val));
        check($sformatf("v%0d disp_sgn", idx), 32'(disp_sgn), 32'(v.sgn));
        check($sformatf("v%0d cmp_pulses", idx), 32'(n_cmp - c0), 32'h1);
        check($sformatf("v%0d alu_pulses", idx), 32'(n_alu - a0), 32'h1);
        press(4'h0);
        check($sformatf("v%0d back_get_a", idx), 32'(disp_msg), 32'h2);
        check($sformatf("v%0d regs_cleared", idx), 32'(cmp_data), 32'h0);
        check($sformatf("v%0d disp_held", idx), 32'(disp_val), 32'(v.val));
    endtask

    initial begin
        int c0, a0;
        vt[0] = '{4'd3,  4'd2,  4'd0, 8'h05, 12'h023, 8'd5,   1'b1 ^ 1'b1};
        vt[1] = '{4'd1,  4'd4,  4'd1, 8'hFD, 12'h141, 8'd3,   1'b1};
        vt[2] = '{4'd0,  4'd0,  4'd2, 8'h80, 12'h200, 8'd128, 1'b1};
        vt[3] = '{4'd0,  4'd0,  4'd0, 8'h00, 12'h000, 8'd0,   1'b0};
        vt[4] = '{4'd15, 4'd15, 4'd3, 8'h7F, 12'h3FF, 8'd127, 1'b0};
        vt[5] = '{4'd7,  4'd9,  4'd3, 8'hFF, 12'h397, 8'd1,   1'b1};

        // Reset with enter held high throughout.
        sw = 8'h05;
        btn_enter = 1'b1;
        tick();
        tick();
        check("rst msg", 32'(disp_msg), 32'h2);
        check("rst disp_val", 32'(disp_val), 32'h0);
        check("rst disp_sgn", 32'(disp_sgn), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst err", 32'(err), 32'h0);
        check("rst cmp_start", 32'(cmp_start), 32'h0);
        check("rst alu_start", 32'(alu_start), 32'h0);
        check("rst cmp_data", 32'(cmp_data), 32'h0);
        rst = 1'b1;
        tick();
        check("held_btn no_edge", 32'(cmp_data), 32'h0);
        btn_enter = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

        // Abort in EXEC; a late alu_done must not touch the display.
        c0 = n_cmp;
        a0 = n_alu;
        press(4'd2);
        press(4'd3);
        enter_op(4'd1);
        cmp_done = 1'b1;
        tick();
        tick();
        cmp_done = 1'b0;
        check("abort in_exec", 32'(alu_start), 32'h1);
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        check("abort busy", 32'(busy), 32'h0);
        check("abort msg", 32'(disp_msg), 32'h2);
        alu_result = 8'h33;
        alu_done   = 1'b1;
        tick();
        alu_done = 1'b0;
        tick();
        check("abort disp_val_held", 32'(disp_val), 32'h1);
        check("abort disp_sgn_held", 32'(disp_sgn), 32'h1);
        check("abort msg_after_done", 32'(disp_msg), 32'h2);
        check("abort busy_after_done", 32'(busy), 32'h0);
        check("abort cmp_pulses", 32'(n_cmp - c0), 32'h1);
        check("abort alu_pulses", 32'(n_alu - a0), 32'h1);

        // Enter and clear together in GET_B: clear wins, a cleared, b not latched.
        press(4'd9);
        check("collide a_latched", 32'(cmp_data), 32'h009);
        sw = 8'h04;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        tick();
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        check("collide cmp_data", 32'(cmp_data), 32'h0);
        check("collide msg", 32'(disp_msg), 32'h2);
        tick();

        // Illegal op code.
        c0 = n_cmp;
        press(4'd1);
        press(4'd1);
        enter_op(4'd7);
        check("op_err err", 32'(err), 32'h1);
        check("op_err msg", 32'(disp_msg), 32'h3);
        check("op_err cmp_start", 32'(cmp_start), 32'h0);
        check("op_err busy", 32'(busy), 32'h0);
        check("op_err disp_val", 32'(disp_val), 32'h0);
        tick();
        check("op_err no_pulse", 32'(n_cmp - c0), 32'h0);
        press(4'd0);
        check("op_err exit_msg", 32'(disp_msg), 32'h2);
        check("op_err exit_err", 32'(err), 32'h0);

        // Reset mid-CONV with done already high.
        a0 = n_alu;
        press(4'd4);
        press(4'd5);
        enter_op(4'd2);
        cmp_done = 1'b1;
        rst = 1'b0;
        tick();
        check("midrst busy", 32'(busy), 32'h0);
        check("midrst msg", 32'(disp_msg), 32'h2);
        check("midrst cmp_data", 32'(cmp_data), 32'h0);
        check("midrst alu_start", 32'(alu_start), 32'h0);
        check("midrst cmp_start", 32'(cmp_start), 32'h0);
        check("midrst disp_val", 32'(disp_val), 32'h0);
        rst = 1'b1;
        tick();
        cmp_done = 1'b0;
        tick();
        check("midrst no_alu_pulse", 32'(n_alu - a0), 32'h0);
        check("midrst stays_idle", 32'(busy), 32'h0);

        // CONV with no cmp_done ever arriving.
        press(4'd1);
        press(4'd2);
        enter_op(4'd0);
`ifdef CALC_TIMEOUT_EN
        repeat (14) tick();
        check("tmo before err", 32'(err), 32'h0);
        check("tmo before busy", 32'(busy), 32'h1);
        tick();
        check("tmo err", 32'(err), 32'h1);
        check("tmo msg", 32'(disp_msg), 32'h3);
        check("tmo busy", 32'(busy), 32'h0);
`else
        repeat (1000) tick();
        check("wait busy", 32'(busy), 32'h1);
        check("wait err", 32'(err), 32'h0);
        check("wait msg", 32'(disp_msg), 32'h0);
`endif
        clear_press();
        check("final msg", 32'(disp_msg), 32'h2);
        check("final busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
